// File: rtl/nibble_serial_subtractor_pkg.sv
// Shared types and sizing helpers for the nibble-serial subtractor.
// Pure declarations: no logic, no latency, no flow control.
package sub_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} sub_state_e;

  localparam int NIBBLE = 4;

  function automatic int nibbles(input int w);
    return w / NIBBLE;
  endfunction

endpackage

// File: rtl/nibble_serial_subtractor_lookahead.sv
// 4-bit borrow-lookahead subtract stage: diff = x - y - bin, bout = borrow out of bit 3.
// Purely combinational, zero cycles; no flow control.
module borrow_lookahead_sub4 (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       bin,
  output logic [3:0] diff,
  output logic       bout
);

  logic [3:0] gen;
  logic [3:0] prop;
  logic [4:0] brw;

  assign gen  = ~x & y;
  assign prop = ~(x ^ y);

  // Every borrow is a flat sum of products of gen/prop and bin, so no ripple path.
  assign brw[0] = bin;
  assign brw[1] = gen[0] | (prop[0] & bin);
  assign brw[2] = gen[1] | (prop[1] & gen[0]) | (prop[1] & prop[0] & bin);
  assign brw[3] = gen[2] | (prop[2] & gen[1]) | (prop[2] & prop[1] & gen[0])
                | (prop[2] & prop[1] & prop[0] & bin);
  assign brw[4] = gen[3] | (prop[3] & gen[2]) | (prop[3] & prop[2] & gen[1])
                | (prop[3] & prop[2] & prop[1] & gen[0])
                | (prop[3] & prop[2] & prop[1] & prop[0] & bin);

  assign diff = x ^ y ^ brw[3:0];
  assign bout = brw[4];

endmodule

// File: rtl/nibble_serial_subtractor.sv
// Serial WIDTH-bit subtractor d = a - b - b_in, one nibble per clock, LSB first; result N=WIDTH/4 edges after accept.
// Accepts only in IDLE; the result is held in DONE until out_ready.
module nibble_serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             b_out,
  output logic             ovf
);

  localparam int N  = nibbles(WIDTH);
  localparam int CW = $clog2(N);

  if ((WIDTH % NIBBLE) != 0 || WIDTH < 8) begin : g_bad_width
    $error("nibble_serial_subtractor: WIDTH must be a multiple of 4 and >= 8");
  end

  sub_state_e       state, state_nxt;
  logic [CW-1:0]    cnt;
  logic             borrow;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic [3:0]       x_nib, y_nib, diff_nib;
  logic             bout_nib;
  logic             last;

  assign x_nib = a_reg[int'(cnt)*NIBBLE +: NIBBLE];
  assign y_nib = b_reg[int'(cnt)*NIBBLE +: NIBBLE];
  assign last  = (cnt == CW'(N - 1));

  borrow_lookahead_sub4 u_stage (
    .x    (x_nib),
    .y    (y_nib),
    .bin  (borrow),
    .diff (diff_nib),
    .bout (bout_nib)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = BUSY;
      end
      BUSY: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      borrow <= 1'b0;
      a_reg  <= '0;
      b_reg  <= '0;
      d      <= '0;
      b_out  <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg  <= a;
            b_reg  <= b;
            borrow <= b_in;
            cnt    <= '0;
          end
        end
        BUSY: begin
          d[int'(cnt)*NIBBLE +: NIBBLE] <= diff_nib;
          borrow <= bout_nib;
          cnt    <= cnt + 1'b1;
          // Sign bit of d is diff_nib[3] on the final nibble, before it lands in d.
          if (last) begin
            b_out <= bout_nib;
            ovf   <= (a_reg[WIDTH-1] != b_reg[WIDTH-1]) && (diff_nib[3] != a_reg[WIDTH-1]);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
`timescale 1ns/1ps
// Scoreboard bench: directed vectors with hand-computed results, then random ops against a reference model.
module tb_nibble_serial_subtractor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        b_in = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] d;
  logic        b_out;
  logic        ovf;

  int total = 0;
  int bad   = 0;
  logic [17:0] sb[$];
  logic rand_mode = 1'b0;
  logic or_force  = 1'b0;

  always #10 clk = ~clk;

  nibble_serial_subtractor #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .b_in      (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d         (d),
    .b_out     (b_out),
    .ovf       (ovf)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [17:0] model(input logic [15:0] ma, input logic [15:0] mb, input logic mbin);
    logic [16:0] r;
    logic        v;
    r = {1'b0, ma} - {1'b0, mb} - {16'd0, mbin};
    v = (ma[15] != mb[15]) && (r[15] != ma[15]);
    return {r[15:0], r[16], v};
  endfunction

  // Monitor: one scoreboard entry per output handshake.
  initial begin
    logic [17:0] e;
    forever begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_result: got d=0x%0h with nothing expected", d);
        end else begin
          e = sb.pop_front();
          chk("result_d", {16'd0, d}, {16'd0, e[17:2]});
          chk("result_b_out", {31'd0, b_out}, {31'd0, e[1]});
          chk("result_ovf", {31'd0, ovf}, {31'd0, e[0]});
        end
      end
    end
  end

  // out_ready driver: forced value in directed phases, random in the scoreboard phase.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      out_ready = rand_mode ? ($urandom_range(0, 3) != 0) : or_force;
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic issue(input logic [15:0] ia, input logic [15:0] ib, input logic ibin,
                       input logic [17:0] exp);
    int n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles", n);
      return;
    end
    a = ia; b = ib; b_in = ibin; in_valid = 1'b1;
    sb.push_back(exp);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom); b_in = 1'($urandom);
  endtask

  task automatic wait_valid(output int edges);
    edges = 0;
    while (!out_valid && edges < 50) begin
      @(posedge clk); #1; edges++;
    end
  endtask

  initial begin
    int lat;
    int n;
    logic [15:0] ra, rb;
    logic rbin;

    #3;
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_d", {16'd0, d}, 32'd0);
    chk("reset_flags", {30'd0, b_out, ovf}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    or_force = 1'b1;
    @(posedge clk); #1;

    issue(16'h1234, 16'h0234, 1'b0, {16'h1000, 1'b0, 1'b0});
    wait_valid(lat);
    chk("latency_t1", lat, 32'd4);

    issue(16'h0000, 16'h0001, 1'b0, {16'hFFFF, 1'b1, 1'b0});
    wait_valid(lat);
    chk("latency_t2", lat, 32'd4);

    issue(16'h8000, 16'h0001, 1'b0, {16'h7FFF, 1'b0, 1'b1});
    wait_valid(lat);
    chk("latency_t3a", lat, 32'd4);

    issue(16'h7FFF, 16'hFFFF, 1'b0, {16'h8000, 1'b1, 1'b1});
    wait_valid(lat);
    chk("latency_t3b", lat, 32'd4);

    issue(16'h0010, 16'h000F, 1'b1, {16'h0000, 1'b0, 1'b0});
    wait_valid(lat);
    chk("latency_t4", lat, 32'd4);

    issue(16'h1234, 16'h1234, 1'b1, {16'hFFFF, 1'b1, 1'b0});
    wait_valid(lat);
    chk("latency_eq_bin", lat, 32'd4);

    // Backpressure: result held for 3 cycles, stray in_valid ignored.
    @(posedge clk); #1;
    or_force = 1'b0;
    issue(16'h5678, 16'h1234, 1'b0, {16'h4444, 1'b0, 1'b0});
    wait_valid(lat);
    chk("latency_t5", lat, 32'd4);
    for (int i = 0; i < 3; i++) begin
      chk("hold_d", {16'd0, d}, 32'h4444);
      chk("hold_flags", {30'd0, b_out, ovf}, 32'd0);
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
      chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
      if (i == 1) begin
        a = 16'hFFFF; b = 16'h0000; in_valid = 1'b1;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
    or_force = 1'b1;
    @(posedge clk); #1;
    chk("release_in_ready", {31'd0, in_ready}, 32'd1);
    chk("release_out_valid", {31'd0, out_valid}, 32'd0);

    // Reset during BUSY cycle k=2 aborts the operation.
    issue(16'hAAAA, 16'h1111, 1'b0, {16'h9999, 1'b0, 1'b0});
    @(posedge clk); #1;
    @(posedge clk); #5;
    rst = 1'b1;
    #1;
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    chk("abort_d", {16'd0, d}, 32'd0);
    chk("abort_flags", {30'd0, b_out, ovf}, 32'd0);
    void'(sb.pop_back());
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    issue(16'h00FF, 16'h0F0F, 1'b0, {16'hF1F0, 1'b1, 1'b0});
    wait_valid(lat);
    chk("latency_t6", lat, 32'd4);

    // Random operations with idle gaps and random out_ready.
    @(posedge clk); #1;
    rand_mode = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      ra = 16'($urandom); rb = 16'($urandom); rbin = 1'($urandom);
      if (i % 10 == 0) rb = ra;
      issue(ra, rb, rbin, model(ra, rb, rbin));
    end
    rand_mode = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    chk("drain_empty", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
